// File: rtl/pe_array_drain.sv
// Drains a ROWS x COLS PE accumulator array in row-major order over a valid/ready
// stream, then pulses the block clear. Define PE_DRAIN_SAT_EN to saturate res_data.
module pe_array_drain #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int ACCW = 32,
  parameter int OUTW = 16,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ROWS*COLS*ACCW-1:0] acc_in,
  input  logic [ROWS*COLS-1:0]      acc_valid_in,
  output logic [ROWS-1:0]           drain_en,
  output logic                      acc_clear_block,
  output logic [OUTW-1:0]           res_data,
  output logic [RW-1:0]             res_row,
  output logic [CW-1:0]             res_col,
  output logic                      res_last,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  // Result stream: an element moves when res_valid & res_ready are both high at a
  // rising clk edge. While res_valid=1 and res_ready=0, res_data/res_row/res_col
  // hold. res_ready has no effect while res_valid=0.

  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [ROWS-1:0] drain_en_q;
  logic            clear_q;
  logic            busy_q;

  logic            in_drain;
  logic            at_last;
  logic            xfer;
  logic [IW-1:0]   idx;
  logic [31:0]     base;
  logic [ACCW-1:0] elem;
  logic [OUTW-1:0] elem_out;

  assign in_drain = (state_q == DRAIN);
  assign at_last  = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // Element select from the registered counters.
  always_comb begin
    idx  = IW'(row_q) * IW'(COLS) + IW'(col_q);
    base = 32'(idx) * 32'(ACCW);
    elem = acc_in[base +: ACCW];
  end

`ifdef PE_DRAIN_SAT_EN
  // In range only when every bit from OUTW-1 upward matches the sign bit.
  logic [ACCW-OUTW:0] hi_bits;
  always_comb begin
    hi_bits = elem[ACCW-1:OUTW-1];
    if ((&hi_bits) || (~|hi_bits)) begin
      elem_out = elem[OUTW-1:0];
    end else if (elem[ACCW-1]) begin
      elem_out = {1'b1, {(OUTW-1){1'b0}}};
    end else begin
      elem_out = {1'b0, {(OUTW-1){1'b1}}};
    end
  end
`else
  assign elem_out = elem[OUTW-1:0];
`endif

  assign res_valid = in_drain & acc_valid_in[idx];
  assign res_data  = in_drain ? elem_out : '0;
  assign res_row   = row_q;
  assign res_col   = col_q;
  assign res_last  = in_drain & at_last;
  assign xfer      = res_valid & res_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAIN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (at_last) begin
            state_d = CLEAR;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  // Control outputs are registered from the next-state values so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      drain_en_q <= '0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      drain_en_q <= (state_d == DRAIN) ? (ROWS'(1) << row_d) : '0;
      clear_q    <= (state_d == CLEAR);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign drain_en        = drain_en_q;
  assign acc_clear_block = clear_q;
  assign done            = clear_q;
  assign busy            = busy_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_pe_array_drain.sv
// Scoreboard bench for pe_array_drain (2x2, 32-bit acc, 16-bit results); the reference
// model follows PE_DRAIN_SAT_EN so the same bench covers both builds.
module tb_pe_array_drain;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int ACCW = 32;
  localparam int OUTW = 16;
  localparam int N    = ROWS * COLS;
  localparam int W    = 3 + OUTW;  // {last, row, col, data}

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [N*ACCW-1:0]    acc_in;
  logic [N-1:0]         acc_valid_in;
  logic [ROWS-1:0]      drain_en;
  logic                 acc_clear_block;
  logic [OUTW-1:0]      res_data;
  logic                 res_row;
  logic                 res_col;
  logic                 res_last;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;
  logic                 done;
  logic [1:0]           dbg_state;

  logic [ACCW-1:0] acc_m [N];
  logic [W-1:0]    exp_q [$];
  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int xfer_cnt = 0;

  pe_array_drain #(.ROWS(ROWS), .COLS(COLS), .ACCW(ACCW), .OUTW(OUTW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_in(acc_in),
    .acc_valid_in(acc_valid_in), .drain_en(drain_en),
    .acc_clear_block(acc_clear_block), .res_data(res_data), .res_row(res_row),
    .res_col(res_col), .res_last(res_last), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  assign acc_in = {acc_m[3], acc_m[2], acc_m[1], acc_m[0]};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [OUTW-1:0] model_out(input logic [ACCW-1:0] a);
    longint v;
    v = longint'($signed(a));
`ifdef PE_DRAIN_SAT_EN
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return OUTW'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a started block yields every element in row-major order, last flagged.
  task automatic push_block();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        logic last;
        last = (r == ROWS - 1) && (c == COLS - 1);
        exp_q.push_back({last, 1'(r), 1'(c), model_out(acc_m[r*COLS+c])});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_drain_en"}, 32'(drain_en), 0);
    check({tag, "_clear"}, 32'(acc_clear_block), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"}, 32'(res_data), 0);
    check({tag, "_res_rowcol"}, 32'({res_row, res_col}), 0);
    check({tag, "_res_last"}, 32'(res_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Random ready/valid drain of one block, bounded.
  task automatic run_drain();
    int base_clr;
    bit finished;
    base_clr = clr_cnt;
    finished = 0;
    push_block();
    pulse_start();
    for (int k = 0; k < 300; k++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) acc_valid_in[i] = ($urandom_range(0, 4) != 0);
      tick();
      if (clr_cnt > base_clr) begin
        finished = 1;
        break;
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL drain_timeout: got no clear pulse, required one within 300 cycles");
    end
    acc_valid_in = '1;
    res_ready = 1'b0;
    tick();
    check("drain_end_busy", 32'(busy), 0);
    check("drain_end_queue_empty", 32'(exp_q.size()), 0);
    check("drain_end_one_clear", 32'(clr_cnt - base_clr), 1);
  endtask

  // Monitor: pops and compares on every transfer; watches clear pulses and holds.
  logic            prev_hold = 1'b0;
  logic [OUTW-1:0] prev_data;
  logic [1:0]      prev_rc;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && res_valid) begin
        check("hold_data", 32'(res_data), 32'(prev_data));
        check("hold_rowcol", 32'({res_row, res_col}), 32'(prev_rc));
      end
      if (res_valid && res_ready) begin
        logic [W-1:0] e;
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer: got row %0d col %0d data 0x%0h, required no transfer",
                   res_row, res_col, res_data);
        end else begin
          e = exp_q.pop_front();
          if ({res_last, res_row, res_col, res_data} !== e) begin
            errors++;
            $display("FAIL xfer: got last %0b row %0d col %0d data 0x%0h, required last %0b row %0d col %0d data 0x%0h",
                     res_last, res_row, res_col, res_data, e[W-1], e[W-2], e[W-3], e[OUTW-1:0]);
          end
          check("xfer_drain_en", 32'(drain_en), e[W-2] ? 32'd2 : 32'd1);
        end
      end
      if (acc_clear_block) begin
        clr_cnt++;
        check("clear_done", 32'(done), 1);
        check("clear_busy", 32'(busy), 1);
        check("clear_res_valid", 32'(res_valid), 0);
        check("clear_drain_en", 32'(drain_en), 0);
        check("clear_after_all_elements", 32'(exp_q.size()), 0);
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
      prev_rc   = {res_row, res_col};
    end
  end

  initial begin
    logic [1:0] exp_de   [6];
    logic       exp_clr  [6];
    logic       exp_busy [6];
    int base_clr;
    int base_xfer;
    bit found;

    rst_n = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    acc_valid_in = '0;
    for (int i = 0; i < N; i++) acc_m[i] = '0;
    #12;
    check_all_zero("reset");
    check("reset_state", 32'(dbg_state), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("idle");

    // Basic drain with a fixed cycle-by-cycle profile.
    acc_m[0] = 10; acc_m[1] = 20; acc_m[2] = 30; acc_m[3] = 40;
    acc_valid_in = '1;
    res_ready = 1'b1;
    exp_de   = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    exp_clr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    push_block();
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      start = 1'b0;
      check($sformatf("basic_drain_en_c%0d", k + 1), 32'(drain_en), 32'(exp_de[k]));
      check($sformatf("basic_clear_c%0d", k + 1), 32'(acc_clear_block), 32'(exp_clr[k]));
      check($sformatf("basic_busy_c%0d", k + 1), 32'(busy), 32'(exp_busy[k]));
    end
    check("basic_queue_empty", 32'(exp_q.size()), 0);

    // Backpressure at element (0,1).
    push_block();
    pulse_start();
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (res_valid && res_row == 1'b0 && res_col == 1'b1) begin
        found = 1;
        break;
      end
      tick();
    end
    check("bp_reached_01", 32'(found), 1);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", 32'(res_valid), 1);
      check("bp_data", 32'(res_data), 20);
      check("bp_rowcol", 32'({res_row, res_col}), 32'b01);
    end
    res_ready = 1'b1;
    tick();
    check("bp_advance_data", 32'(res_data), 30);
    check("bp_advance_rowcol", 32'({res_row, res_col}), 32'b10);
    repeat (4) tick();
    check("bp_idle", 32'(busy), 0);

    // Extra start pulses during DRAIN and during CLEAR are ignored.
    base_clr = clr_cnt;
    base_xfer = xfer_cnt;
    push_block();
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc_clear_block) begin
        found = 1;
        break;
      end
    end
    check("swb_reached_clear", 32'(found), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("swb_xfers", 32'(xfer_cnt - base_xfer), 4);
    check("swb_clears", 32'(clr_cnt - base_clr), 1);
    check("swb_busy", 32'(busy), 0);
    check("swb_state_idle", 32'(dbg_state), 0);

    // Width handling.
    acc_m[0] = 32'h0001_2345; acc_m[1] = 32'hFFFF_0000;
    acc_m[2] = 32'h0000_7FFF; acc_m[3] = 32'hFFFF_8000;
    run_drain();

    // Reset mid-drain at element (1,0).
    for (int i = 0; i < N; i++) acc_m[i] = $urandom;
    acc_valid_in = '1;
    res_ready = 1'b1;
    base_clr = clr_cnt;
    push_block();
    pulse_start();
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (res_valid && res_row == 1'b1 && res_col == 1'b0) begin
        found = 1;
        break;
      end
      tick();
    end
    check("rst_reached_10", 32'(found), 1);
    res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    exp_q.delete();
    tick();
    check_all_zero("rst_held");
    rst_n = 1'b1;
    tick();
    check("rst_no_clear", 32'(clr_cnt - base_clr), 0);
    check("rst_state_idle", 32'(dbg_state), 0);
    run_drain();

    // Randomized blocks, including extreme values.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: acc_m[i] = $urandom_range(0, 65535);
          1: acc_m[i] = 32'hFFFF_FFFF - $urandom_range(0, 65535);
          default: acc_m[i] = $urandom;
        endcase
      end
      run_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
